// File: rtl/explosao_pkg.sv
// explosao_pkg: phase encoding, segment patterns and glyphs for the explosion animation
package explosao_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLASH   = 2'd1,
    BLANK   = 2'd2,
    MESSAGE = 2'd3
  } phase_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] FLASH_AB  = 7'b1111100;
  localparam logic [6:0] FLASH_CD  = 7'b1110011;
  localparam logic [6:0] FLASH_EF  = 7'b1001111;
  localparam logic [6:0] FLASH_G   = 7'b0111111;
  localparam logic [6:0] MSG_U     = 7'b1000001;
  localparam logic [6:0] MSG_D1    = 7'b0100001;
  localparam logic [6:0] MSG_I     = 7'b1111001;
  localparam logic [6:0] MSG_E     = 7'b0000110;
  localparam logic [6:0] MSG_D0    = 7'b0100001;
  function automatic logic [6:0] flash_seg(input logic [1:0] p);
    return p == 2'd0 ? FLASH_AB : p == 2'd1 ? FLASH_CD : p == 2'd2 ? FLASH_EF : FLASH_G;
  endfunction
  function automatic logic [6:0] msg_seg(input int k);
    return k == 0 ? MSG_D0 : k == 1 ? MSG_E : k == 2 ? MSG_I : k == 3 ? MSG_D1 : k == 4 ? MSG_U : SEG_BLANK;
  endfunction
endpackage

// File: rtl/explosao_prescaler.sv
// explosao_prescaler: counts TICKS_PER_FRAME cycles and pulses tick on the last one
module explosao_prescaler #(
  parameter int TICKS_PER_FRAME = 5000000
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = TICKS_PER_FRAME > 1 ? $clog2(TICKS_PER_FRAME) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS_PER_FRAME - 1);
  logic [W-1:0] cnt;
  assign tick = en && cnt == LAST;
  // count while enabled, wrap on the frame tick
  always_ff @(posedge clk)
    cnt <= clr || tick ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/explosao_animador.sv
// explosao_animador: FLASH/BLANK explosion then "udied" message; EXPLOSAO_PISCA_MSG_EN makes the message blink
module explosao_animador
  import explosao_pkg::*;
#(
  parameter int N_HEX           = 8,
  parameter int N_LEDR          = 18,
  parameter int TICKS_PER_FRAME = 5000000,
  parameter int FLASH_FRAMES    = 32,
  parameter int BLANK_FRAMES    = 32,
  parameter int N_CICLOS        = 1
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic               TEMPO_ACABOU,
  output logic [7*N_HEX-1:0] HEX,
  output logic [N_LEDR-1:0]  LEDR,
  output logic [1:0]         FASE,
  output logic               FIM
);
  localparam int FMAX = FLASH_FRAMES > BLANK_FRAMES ? FLASH_FRAMES : BLANK_FRAMES;
  localparam int FW0  = FMAX > 1 ? $clog2(FMAX) : 1;
`ifdef EXPLOSAO_PISCA_MSG_EN
  localparam int FW_MIN = 4;
`else
  localparam int FW_MIN = 2;
`endif
  localparam int FW = FW0 > FW_MIN ? FW0 : FW_MIN;
  localparam int CW = $clog2(N_CICLOS + 1);
  localparam logic [FW-1:0] FLAST = FW'(FLASH_FRAMES - 1);
  localparam logic [FW-1:0] BLAST = FW'(BLANK_FRAMES - 1);
  localparam logic [CW-1:0] CLAST = CW'(N_CICLOS - 1);
  phase_t state, state_nx;
  logic [FW-1:0] frame, frame_nx;
  logic [CW-1:0] cyc, cyc_nx;
  logic tick, run, msg_on;
  logic [7*N_HEX-1:0] hex_nx;
  logic [N_LEDR-1:0] ledr_nx;
`ifdef EXPLOSAO_PISCA_MSG_EN
  assign run    = state != IDLE;
  assign msg_on = ~frame[3];
`else
  assign run    = state == FLASH || state == BLANK;
  assign msg_on = 1'b1;
`endif
  explosao_prescaler #(.TICKS_PER_FRAME(TICKS_PER_FRAME)) u_presc (
    .clk  (CLOCK),
    .clr  (!RESET_N || !TEMPO_ACABOU || state == IDLE),
    .en   (run),
    .tick (tick)
  );
  // phase and counter register
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state <= IDLE;
      frame <= '0;
      cyc   <= '0;
    end else begin
      state <= state_nx;
      frame <= frame_nx;
      cyc   <= cyc_nx;
    end
  end
  // next phase: dropping TEMPO_ACABOU beats any frame or phase transition
  always_comb begin
    state_nx = state;
    frame_nx = frame;
    cyc_nx   = cyc;
    if (!TEMPO_ACABOU || state == IDLE) begin
      state_nx = TEMPO_ACABOU ? FLASH : IDLE;
      frame_nx = '0;
      cyc_nx   = '0;
    end else if (tick) begin
      case (state)
        FLASH: begin
          state_nx = frame == FLAST ? BLANK : FLASH;
          frame_nx = frame == FLAST ? '0 : frame + 1'b1;
        end
        BLANK: begin
          state_nx = frame != BLAST ? BLANK : cyc == CLAST ? MESSAGE : FLASH;
          frame_nx = frame == BLAST ? '0 : frame + 1'b1;
          cyc_nx   = frame == BLAST ? cyc + 1'b1 : cyc;
        end
        default: frame_nx = frame + 1'b1;
      endcase
    end
  end
  // display patterns derived from the current phase and frame
  always_comb begin
    hex_nx  = '1;
    ledr_nx = '0;
    for (int k = 0; k < N_HEX; k++)
      hex_nx[7*k +: 7] = state == FLASH ? flash_seg(frame[1:0]) :
                         state == MESSAGE && msg_on ? msg_seg(k) : SEG_BLANK;
    for (int i = 0; i < N_LEDR; i++)
      ledr_nx[i] = state == FLASH && 2'(i) == frame[1:0];
  end
  // registered outputs, one cycle behind the phase register
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      HEX  <= '1;
      LEDR <= '0;
      FASE <= IDLE;
      FIM  <= 1'b0;
    end else begin
      HEX  <= hex_nx;
      LEDR <= ledr_nx;
      FASE <= state;
      FIM  <= state == MESSAGE;
    end
  end
endmodule

// File: tb/tb_explosao_animador.sv
// tb_explosao_animador: randomized bench with a timeline model of the explosion animation
module tb_explosao_animador;
  localparam int NH = 8, NL = 18, TPF = 2, FF = 4, BF = 2, NC = 2;
  localparam int PER = (FF + BF) * TPF;
  localparam logic [6:0] PAT [4] = '{7'b1111100, 7'b1110011, 7'b1001111, 7'b0111111};
  logic clk, rst_n, tempo;
  logic [7*NH-1:0] hex;
  logic [NL-1:0] ledr;
  logic [1:0] fase;
  logic fim;
  int errors = 0, checks = 0;
  bit idle_m = 1, valid = 0;
  int t_m = 0;
  logic [7*NH-1:0] eh, msg_word, f0, f1, f3;
  logic [NL-1:0] el;
  logic [1:0] ef;
  logic efm;

  explosao_animador #(
    .N_HEX(NH), .N_LEDR(NL), .TICKS_PER_FRAME(TPF),
    .FLASH_FRAMES(FF), .BLANK_FRAMES(BF), .N_CICLOS(NC)
  ) dut (
    .CLOCK(clk), .RESET_N(rst_n), .TEMPO_ACABOU(tempo),
    .HEX(hex), .LEDR(ledr), .FASE(fase), .FIM(fim)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // t = cycles since the animation started; phase follows from plain timeline arithmetic
  function automatic void model_out(input bit idl, input int t, output logic [7*NH-1:0] h,
                                    output logic [NL-1:0] l, output logic [1:0] f, output logic fm);
    int r, p, m;
    bit show;
    h = '1; l = '0; f = 0; fm = 0;
    if (!idl) begin
      if (t >= NC * PER) begin
        f = 3; fm = 1;
        m = t - NC * PER;
`ifdef EXPLOSAO_PISCA_MSG_EN
        show = ((m / TPF) % 16) < 8;
`else
        show = m >= 0;
`endif
        if (show) h = msg_word;
      end else begin
        r = t % PER;
        if (r < FF * TPF) begin
          f = 1;
          p = (r / TPF) % 4;
          for (int d = 0; d < NH; d++) h[7*d +: 7] = PAT[p];
          for (int i = 0; i < NL; i++) l[i] = (i % 4) == p;
        end else f = 2;
      end
    end
  endfunction

  always @(posedge clk) begin
    model_out(idle_m || !rst_n, t_m, eh, el, ef, efm);
    valid = 1;
    if (!rst_n || !tempo) idle_m = 1;
    else if (idle_m) begin idle_m = 0; t_m = 0; end
    else t_m = t_m + 1;
  end

  always @(negedge clk) begin
    if (valid) begin
      checks++;
      if ({hex, ledr, fase, fim} !== {eh, el, ef, efm}) begin
        errors++;
        $display("FAIL model t=%0d: HEX=%h LEDR=%h FASE=%0d FIM=%b, expected HEX=%h LEDR=%h FASE=%0d FIM=%b",
                 t_m, hex, ledr, fase, fim, eh, el, ef, efm);
      end
    end
  end

  task automatic lit(input string name, input logic [7*NH-1:0] h, input logic [NL-1:0] l,
                     input logic [1:0] f, input logic fm);
    checks++;
    if ({hex, ledr, fase, fim} !== {h, l, f, fm}) begin
      errors++;
      $display("FAIL %s: HEX=%h LEDR=%h FASE=%0d FIM=%b, expected HEX=%h LEDR=%h FASE=%0d FIM=%b",
               name, hex, ledr, fase, fim, h, l, f, fm);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    msg_word = {7'h7F, 7'h7F, 7'h7F, 7'b1000001, 7'b0100001, 7'b1111001, 7'b0000110, 7'b0100001};
    f0 = {8{7'b1111100}};
    f1 = {8{7'b1110011}};
    f3 = {8{7'b0111111}};
    rst_n = 0; tempo = 0;
    tick(2);
    lit("reset", 56'hFF_FFFF_FFFF_FFFF, '0, 0, 0);
    rst_n = 1;
    tick(1);
    tempo = 1;
    tick(2);
    lit("flash_p0", f0, 18'h11111, 1, 0);
    tick(2);
    lit("flash_p1", f1, 18'h22222, 1, 0);
    tick(4);
    lit("flash_p3", f3, 18'h08888, 1, 0);
    tick(18);
    lit("message", msg_word, '0, 3, 1);
`ifdef EXPLOSAO_PISCA_MSG_EN
    tick(16);
    lit("message_blink_off", '1, '0, 3, 1);
    tick(16);
    lit("message_blink_on", msg_word, '0, 3, 1);
`else
    tick(110);
    lit("message_hold", msg_word, '0, 3, 1);
`endif
    tempo = 0;
    tick(2);
    lit("drop_idle", '1, '0, 0, 0);
    tempo = 1;
    tick(2);
    lit("second_start", f0, 18'h11111, 1, 0);
    tick(8);
    tempo = 0;
    tick(2);
    lit("abort_blank", '1, '0, 0, 0);
    tempo = 1;
    tick(2);
    lit("restart_frame0", f0, 18'h11111, 1, 0);
    tick(23);
    lit("restart_second_blank", '1, '0, 2, 0);
    tick(1);
    lit("restart_message", msg_word, '0, 3, 1);
    tick(5);
    rst_n = 0;
    tick(1);
    lit("reset_in_message", '1, '0, 0, 0);
    rst_n = 1;
    tick(2);
    lit("after_reset_flash", f0, 18'h11111, 1, 0);
    tick(23);
    lit("after_reset_blank", '1, '0, 2, 0);
    tick(1);
    lit("after_reset_message", msg_word, '0, 3, 1);
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      tempo = $urandom_range(0, 99) < 96;
      rst_n = $urandom_range(0, 299) != 0;
    end
    rst_n = 1; tempo = 0;
    tick(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/explosao_animador.md
Name: explosao_animador

Overview:
- Parametrised successor of the timer's end-of-time explosion animation.
- Drives N_HEX seven-segment digits (active-low) and N_LEDR red LEDs while TEMPO_ACABOU is high.
- Sequence: N_CICLOS repetitions of FLASH/BLANK, then a fixed "udied" message held indefinitely.
- Sits between the countdown core and the board display mux; frame rate comes from an internal prescaler, not the raw clock.

Parameters:
- N_HEX, 8: number of 7-segment digits driven; minimum 1.
- N_LEDR, 18: number of red LEDs driven; minimum 1.
- TICKS_PER_FRAME, 5000000: CLOCK cycles per animation frame; minimum 1.
- FLASH_FRAMES, 32: frames per FLASH phase; minimum 1.
- BLANK_FRAMES, 32: frames per BLANK phase; minimum 1.
- N_CICLOS, 1: number of FLASH+BLANK repetitions before MESSAGE; minimum 1.

Ports:
- CLOCK  in  1  system clock
- RESET_N  in  1  synchronous, active-low reset
- TEMPO_ACABOU  in  1  level trigger; high runs the animation, low returns to IDLE
- HEX  out  7*N_HEX  digit k occupies bits [7k+6:7k]; segment bit 0=a .. 6=g; active-low
- LEDR  out  N_LEDR  active-high LEDs
- FASE  out  2  current phase: 0=IDLE, 1=FLASH, 2=BLANK, 3=MESSAGE
- FIM  out  1  high while in MESSAGE

Behaviour:
- One clock domain (CLOCK); reset is synchronous, active-low (RESET_N). Both are fixed decisions.
- Reset state: IDLE; prescaler, frame counter and cycle counter all 0.
- Reset output values: HEX all ones, LEDR 0, FASE 0, FIM 0.
- All outputs are registered. Each output reflects the state and counters present after the previous edge (1-cycle latency).
- State transitions:
  - IDLE: TEMPO_ACABOU=1 sampled at an edge -> FLASH; prescaler, frame and cycle counters cleared.
  - FLASH: frame counter advances when the prescaler reaches TICKS_PER_FRAME-1 (the prescaler then wraps to 0). When the last frame (FLASH_FRAMES-1) expires -> BLANK, frame counter 0.
  - BLANK: when frame BLANK_FRAMES-1 expires, increment the cycle counter. If cycles == N_CICLOS -> MESSAGE, else -> FLASH with frame 0.
  - MESSAGE: terminal state; counters frozen, except the prescaler and frame counter when EXPLOSAO_PISCA_MSG_EN is defined.
- Phase durations: FLASH = FLASH_FRAMES*TICKS_PER_FRAME cycles; BLANK = BLANK_FRAMES*TICKS_PER_FRAME cycles.
- TEMPO_ACABOU=0 in any non-IDLE state -> IDLE at the next edge, counters cleared. This overrides a same-edge frame or phase transition.
- RESET_N=0 overrides everything. Reset mid-sequence with TEMPO_ACABOU held high gives one cycle of IDLE, then a restart at FLASH frame 0.
- FLASH outputs (p = frame[1:0]), identical on every digit:
  - p=0: segments a,b lit -> 7'b1111100
  - p=1: segments c,d lit -> 7'b1110011
  - p=2: segments e,f lit -> 7'b1001111
  - p=3: segment g lit -> 7'b0111111
  - LEDR[i]=1 iff (i mod 4)==p.
- BLANK outputs: HEX all ones, LEDR 0.
- MESSAGE outputs:
  - Digits 4..0 show u, d, i, e, d (7'b1000001, 7'b0100001, 7'b1111001, 7'b0000110, 7'b0100001).
  - Digits >=5 are blank.
  - If N_HEX<5, only the rightmost N_HEX characters are shown.
  - LEDR 0, FIM 1.
- Counter widths are $clog2 of the respective maximum, with a minimum of 1 bit. No overflow is possible within legal parameters.

Optional Feature:
- Macro EXPLOSAO_PISCA_MSG_EN.
- Defined: in MESSAGE the prescaler and frame counter keep running. The message is shown while frame[3]==0 and all digits are blank while frame[3]==1, giving an 8-frame on/8-frame off blink. The frame counter wraps freely. FIM stays 1 throughout.
- Undefined: the message is steady and the counters are frozen.

Decomposition:
- Package explosao_pkg holds:
  - the phase enum (IDLE/FLASH/BLANK/MESSAGE, 2-bit, values as on FASE);
  - the blank-digit constant 7'h7F;
  - the four FLASH segment patterns;
  - the five message glyph constants.
- Sub-module explosao_prescaler: parametrised TICKS_PER_FRAME counter with synchronous clear, emitting a one-cycle frame pulse. The top level holds the FSM and the output registers.

Test Plan (TICKS_PER_FRAME=2, FLASH_FRAMES=4, BLANK_FRAMES=2, N_CICLOS=2, N_HEX=8, N_LEDR=18):
- Reset: RESET_N=0 for 2 cycles -> HEX all ones (56'hFF_FFFF_FFFF_FFFF), LEDR 0, FASE 0, FIM 0.
- Trigger: TEMPO_ACABOU=1 sampled at edge 0 -> after edge 1 every digit is 7'b1111100 and LEDR=18'h11111. After edge 3 every digit is 7'b1110011 and LEDR=18'h22222. After edge 7 every digit is 7'b0111111 and LEDR=18'h08888.
- Full run: FASE sequence after edges 1..25 is 1 (x8), 2 (x4), 1 (x8), 2 (x4), then 3 from edge 25 with FIM=1. In MESSAGE, HEX digits 4..0 = u,d,i,e,d and digits 7..5 = 7'h7F, held for more than 100 cycles.
- Abort: TEMPO_ACABOU=0 during the first BLANK -> the next output is IDLE. Re-asserting it restarts FLASH frame 0 (LEDR=18'h11111), and the cycle count restarts, so two full cycles occur before MESSAGE.
- Reset mid-MESSAGE: TEMPO_ACABOU held 1, RESET_N=0 for 1 cycle -> outputs return to IDLE values. After release the FLASH sequence restarts, and FASE reaches 3 again 24 cycles after the first FLASH edge.
- With EXPLOSAO_PISCA_MSG_EN defined: in MESSAGE the digits alternate between glyphs and all-blank every 16 cycles while FIM stays 1. Without the macro the glyphs are constant.
